// File: rtl/ovl_pkg.sv
// Shared types and fire-bit encoding for the OVL window checkers.
package ovl_pkg;

  typedef enum logic {OVL_IDLE = 1'b0, OVL_WAIT = 1'b1} ovl_win_state_e;

  localparam int OVL_FIRE_ILLEGAL = 0;
  localparam int OVL_FIRE_TIMEOUT = 1;
  localparam int OVL_FIRE_EARLY   = 2;
  localparam int OVL_FIRE_W       = 3;

  // One-hot fire vector for a single violation class.
  function automatic logic [OVL_FIRE_W-1:0] ovl_fire_bit(input int idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/ovl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module ovl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Count register: reset and clear dominate, increment stops at the top value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + W'(1);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ovl_transition_window.sv
// Checks that test_expr leaves start_state only to next_state, after a dwell of MIN_CKS..MAX_CKS cycles.
module ovl_transition_window
  import ovl_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int MIN_CKS = 1,
  parameter int MAX_CKS = 0,
  parameter int CNT_W   = 8,
  parameter int DWELL_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] test_expr,
  input  logic [WIDTH-1:0] start_state,
  input  logic [WIDTH-1:0] next_state,
  output logic [2:0]       fire,
  output logic             armed,
  output logic [CNT_W-1:0] fire_count
);

  localparam int DWELL_NEED = ((MIN_CKS > MAX_CKS) ? MIN_CKS : MAX_CKS) + 1;
  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_CKS);
  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_CKS);

  if (MAX_CKS != 0 && MAX_CKS < MIN_CKS) begin : g_bad_range
    $error("ovl_transition_window: MAX_CKS (%0d) below MIN_CKS (%0d)", MAX_CKS, MIN_CKS);
  end
  if ($clog2(DWELL_NEED + 1) > DWELL_W) begin : g_bad_dwell
    $error("ovl_transition_window: DWELL_W (%0d) cannot hold %0d", DWELL_W, DWELL_NEED);
  end

  ovl_win_state_e   state_r, state_s;
  logic [WIDTH-1:0] st_r, nx_r;
  logic [2:0]       fire_r, fire_s;
  logic             armed_r;
  logic             arm_s, dwell_inc_s, dwell_clr_s;
  logic [DWELL_W-1:0] dwell_s;

  // Next-state, dwell control and violation classification.
  always_comb begin
    state_s     = state_r;
    fire_s      = 3'b000;
    arm_s       = 1'b0;
    dwell_inc_s = 1'b0;
    dwell_clr_s = 1'b0;
    case (state_r)
      OVL_IDLE: begin
        // Degenerate start==next never opens a window.
        if (enable && (test_expr == start_state) && (start_state != next_state)) begin
          state_s     = OVL_WAIT;
          arm_s       = 1'b1;
          dwell_inc_s = 1'b1;
        end else begin
          dwell_clr_s = 1'b1;
        end
      end
      OVL_WAIT: begin
        if (!enable) begin
          state_s     = OVL_IDLE;
          dwell_clr_s = 1'b1;
        end else if (test_expr == st_r) begin
          if ((MAX_CKS != 0) && (dwell_s >= MAX_D)) begin
            fire_s      = ovl_fire_bit(OVL_FIRE_TIMEOUT);
            state_s     = OVL_IDLE;
            dwell_clr_s = 1'b1;
          end else begin
            dwell_inc_s = 1'b1;
          end
        end else if (test_expr == nx_r) begin
          if (dwell_s < MIN_D) begin
            fire_s = ovl_fire_bit(OVL_FIRE_EARLY);
          end else begin
            fire_s = 3'b000;
          end
          state_s     = OVL_IDLE;
          dwell_clr_s = 1'b1;
        end else begin
          fire_s      = ovl_fire_bit(OVL_FIRE_ILLEGAL);
          state_s     = OVL_IDLE;
          dwell_clr_s = 1'b1;
        end
      end
      default: begin
        state_s     = OVL_IDLE;
        dwell_clr_s = 1'b1;
      end
    endcase
  end

  // State, latched window endpoints and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= OVL_IDLE;
      st_r    <= {WIDTH{1'b0}};
      nx_r    <= {WIDTH{1'b0}};
      fire_r  <= 3'b000;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      fire_r  <= fire_s;
      armed_r <= (state_s == OVL_WAIT);
      if (arm_s) begin
        st_r <= start_state;
        nx_r <= next_state;
      end
    end
  end

  ovl_sat_counter #(.W(DWELL_W)) u_dwell (
    .clk   (clock),
    .reset (reset),
    .clr   (dwell_clr_s),
    .inc   (dwell_inc_s),
    .q     (dwell_s)
  );

  ovl_sat_counter #(.W(CNT_W)) u_fire_count (
    .clk   (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (|fire_s),
    .q     (fire_count)
  );

  assign fire  = fire_r;
  assign armed = armed_r;

endmodule

// File: tb/tb_ovl_transition_window.sv
// Bench for ovl_transition_window: bounded (MAX=4) and unbounded (MAX=0) instances against a window model.
module tb_ovl_transition_window;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] test_expr = 2'b01;
  logic [1:0] start_state = 2'b00;
  logic [1:0] next_state = 2'b11;

  logic [2:0] fire4, fire0;
  logic       armed4, armed0;
  logic [7:0] cnt4, cnt0;

  int compared = 0;
  int mismatched = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ovl_transition_window #(.WIDTH(2), .MIN_CKS(2), .MAX_CKS(4), .CNT_W(8), .DWELL_W(8)) dut (
    .clock(clk), .reset(reset), .enable(enable), .test_expr(test_expr),
    .start_state(start_state), .next_state(next_state),
    .fire(fire4), .armed(armed4), .fire_count(cnt4)
  );

  ovl_transition_window #(.WIDTH(2), .MIN_CKS(2), .MAX_CKS(0), .CNT_W(8), .DWELL_W(8)) dut_ub (
    .clock(clk), .reset(reset), .enable(enable), .test_expr(test_expr),
    .start_state(start_state), .next_state(next_state),
    .fire(fire0), .armed(armed0), .fire_count(cnt0)
  );

  typedef struct {
    bit         open;
    int         age;
    logic [1:0] st;
    logic [1:0] nx;
    logic [2:0] fire;
    int         count;
  } mdl_t;

  mdl_t m4 = '{open: 1'b0, age: 0, st: 2'b00, nx: 2'b00, fire: 3'b000, count: 0};
  mdl_t m0 = '{open: 1'b0, age: 0, st: 2'b00, nx: 2'b00, fire: 3'b000, count: 0};

  // Window rules: age = cycles spent in start_state since the window opened.
  function automatic mdl_t mdl_next(input mdl_t m, input int max_cks, input bit rst, input bit en,
                                    input logic [1:0] te, input logic [1:0] s, input logic [1:0] n);
    mdl_t r;
    r = m;
    r.fire = 3'b000;
    if (rst) begin
      r.open = 1'b0; r.age = 0; r.st = 2'b00; r.nx = 2'b00; r.count = 0;
      return r;
    end
    if (!m.open) begin
      if (en && te == s && s != n) begin
        r.open = 1'b1; r.age = 1; r.st = s; r.nx = n;
      end
    end else if (!en) begin
      r.open = 1'b0;
    end else if (te == m.st) begin
      if (max_cks != 0 && m.age == max_cks) begin
        r.fire = 3'b010; r.open = 1'b0;
      end else begin
        r.age = m.age + 1;
      end
    end else if (te == m.nx) begin
      if (m.age < 2) r.fire = 3'b100;
      r.open = 1'b0;
    end else begin
      r.fire = 3'b001; r.open = 1'b0;
    end
    if (r.fire != 3'b000 && r.count < 255) r.count = r.count + 1;
    return r;
  endfunction

  always @(posedge clk) begin
    m4 <= mdl_next(m4, 4, reset, enable, test_expr, start_state, next_state);
    m0 <= mdl_next(m0, 0, reset, enable, test_expr, start_state, next_state);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m4_fire",  32'(fire4),  32'(m4.fire));
      check("m4_armed", 32'(armed4), 32'(m4.open));
      check("m4_count", 32'(cnt4),   32'(m4.count));
      check("m0_fire",  32'(fire0),  32'(m0.fire));
      check("m0_armed", 32'(armed0), 32'(m0.open));
      check("m0_count", 32'(cnt0),   32'(m0.count));
    end
  end

  // Apply inputs just after an edge, then consume exactly one sampling edge.
  task automatic drive(input bit en, input logic [1:0] te);
    enable = en;
    test_expr = te;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 2'b01);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    check("rst_armed", 32'(armed4), 32'd0);
    check("rst_fire",  32'(fire4),  32'd0);
    check("rst_count", 32'(cnt4),   32'd0);

    // 1) legal pass after two cycles in start
    drive(1'b1, 2'b00);
    check("s1_armed1", 32'(armed4), 32'd1);
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b11);
    check("s1_armed0", 32'(armed4), 32'd0);
    check("s1_fire",   32'(fire4),  32'd0);
    check("s1_count",  32'(cnt4),   32'd0);

    // 2) illegal successor
    do_reset();
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b10);
    check("s2_fire",  32'(fire4),  32'b001);
    check("s2_armed", 32'(armed4), 32'd0);
    check("s2_count", 32'(cnt4),   32'd1);
    drive(1'b1, 2'b01);
    check("s2_pulse", 32'(fire4),  32'd0);

    // 3) timeout after five samples of start, then re-arm
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b00);
    check("s3_fire",  32'(fire4),  32'b010);
    check("s3_armed", 32'(armed4), 32'd0);
    check("s3_count", 32'(cnt4),   32'd1);
    drive(1'b1, 2'b00);
    check("s3_rearm", 32'(armed4), 32'd1);

    // 4) early exit; unbounded instance never times out
    do_reset();
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b11);
    check("s4_fire", 32'(fire4), 32'b100);
    check("s4_count", 32'(cnt4), 32'd1);
    for (int i = 0; i < 50; i++) drive(1'b1, 2'b00);
    check("s4_ub_fire",  32'(fire0),  32'd0);
    check("s4_ub_armed", 32'(armed0), 32'd1);
    drive(1'b1, 2'b11);
    check("s4_ub_pass", 32'(fire0), 32'd0);

    // 5) latched endpoints survive input changes; enable drop aborts silently
    do_reset();
    drive(1'b1, 2'b00);
    start_state = 2'b01;
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b11);
    check("s5_latched_fire", 32'(fire4), 32'd0);
    check("s5_latched_cnt",  32'(cnt4),  32'd0);
    start_state = 2'b00;
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b10);
    check("s5_abort_armed", 32'(armed4), 32'd0);
    check("s5_abort_fire",  32'(fire4),  32'd0);

    // degenerate start==next never arms
    next_state = 2'b00;
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00);
    check("degen_armed", 32'(armed4), 32'd0);
    next_state = 2'b11;

    // other endpoint pair: 01 -> 10, illegal 11
    start_state = 2'b01;
    next_state = 2'b10;
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    check("alt_fire", 32'(fire4), 32'b001);
    start_state = 2'b00;
    next_state = 2'b11;

    // 6) reset mid-window, then saturate the fire count
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00);
    reset = 1'b1;
    drive(1'b1, 2'b10);
    reset = 1'b0;
    check("s6_rst_armed", 32'(armed4), 32'd0);
    check("s6_rst_fire",  32'(fire4),  32'd0);
    check("s6_rst_count", 32'(cnt4),   32'd0);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b00);
      drive(1'b1, 2'b10);
      if (i == 253) check("s6_count254", 32'(cnt4), 32'd254);
    end
    check("s6_sat", 32'(cnt4), 32'd255);
    drive(1'b1, 2'b01);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
